// File: rtl/rs_gen.sv
// rs_gen: reservation station with age-ordered dispatch and multi-channel CDB wakeup.
// Optional feature macro RS_BYPASS_EN: an issuing operand captures a matching CDB result on the issue edge.
module rs_gen #(
  parameter int DEPTH   = 8,
  parameter int NCDB    = 2,
  parameter int ROB_LOG = 4,
  parameter int OP_LOG  = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       issue_valid,
  input  logic [OP_LOG-1:0]          issue_op,
  input  logic [31:0]                issue_Imm,
  input  logic [31:0]                issue_CurPC,
  input  logic [ROB_LOG-1:0]         issue_DestRob,
  input  logic [31:0]                issue_Vj,
  input  logic [31:0]                issue_Vk,
  input  logic                       issue_Rj,
  input  logic                       issue_Rk,
  input  logic [ROB_LOG-1:0]         issue_Qj,
  input  logic [ROB_LOG-1:0]         issue_Qk,
  input  logic [NCDB-1:0]            cdb_valid,
  input  logic [NCDB*ROB_LOG-1:0]    cdb_RobId,
  input  logic [NCDB*32-1:0]         cdb_value,
  output logic                       FU_enable,
  input  logic                       FU_ready,
  output logic [OP_LOG-1:0]          FU_op,
  output logic [31:0]                FU_Vj,
  output logic [31:0]                FU_Vk,
  output logic [31:0]                FU_Imm,
  output logic [31:0]                FU_CurPC,
  output logic [ROB_LOG-1:0]         FU_DestRob,
  output logic                       RS_next_full,
  output logic [$clog2(DEPTH+1)-1:0] RS_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]   busy_q, busy_d;
  logic [DEPTH-1:0]   rj_q, rj_d;
  logic [DEPTH-1:0]   rk_q, rk_d;
  // older_q[i][j] set means entry i was issued before entry j
  logic [DEPTH-1:0]   older_q [DEPTH];
  logic [DEPTH-1:0]   older_d [DEPTH];

  logic [OP_LOG-1:0]  op_q   [DEPTH];
  logic [OP_LOG-1:0]  op_d   [DEPTH];
  logic [31:0]        vj_q   [DEPTH];
  logic [31:0]        vj_d   [DEPTH];
  logic [31:0]        vk_q   [DEPTH];
  logic [31:0]        vk_d   [DEPTH];
  logic [31:0]        imm_q  [DEPTH];
  logic [31:0]        imm_d  [DEPTH];
  logic [31:0]        pc_q   [DEPTH];
  logic [31:0]        pc_d   [DEPTH];
  logic [ROB_LOG-1:0] dest_q [DEPTH];
  logic [ROB_LOG-1:0] dest_d [DEPTH];
  logic [ROB_LOG-1:0] qj_q   [DEPTH];
  logic [ROB_LOG-1:0] qj_d   [DEPTH];
  logic [ROB_LOG-1:0] qk_q   [DEPTH];
  logic [ROB_LOG-1:0] qk_d   [DEPTH];

  logic               fu_enable_q, fu_enable_d;
  logic [OP_LOG-1:0]  fu_op_q, fu_op_d;
  logic [31:0]        fu_vj_q, fu_vj_d;
  logic [31:0]        fu_vk_q, fu_vk_d;
  logic [31:0]        fu_imm_q, fu_imm_d;
  logic [31:0]        fu_pc_q, fu_pc_d;
  logic [ROB_LOG-1:0] fu_dest_q, fu_dest_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [DEPTH-1:0]   ready;
  logic               oldest;
  logic               sel_found, free_found;
  logic [IDX_W-1:0]   sel_idx, free_idx;
  logic               slot_free, disp_fire, disp_now;

  // Oldest ready entry and lowest free slot, both from registered state
  always_comb begin
    ready      = busy_q & rj_q & rk_q;
    oldest     = 1'b0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      oldest = ready[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && ready[j] && older_q[j][i]) oldest = 1'b0;
      end
      if (oldest && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (!busy_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign slot_free    = !fu_enable_q || FU_ready;
  assign disp_fire    = slot_free && sel_found;
  assign disp_now     = rdy && !flush && disp_fire;
  assign RS_next_full = (int'(count_q) + int'(issue_valid) - int'(disp_now)) >= DEPTH;

  always_comb begin
    busy_d      = busy_q;
    rj_d        = rj_q;
    rk_d        = rk_q;
    older_d     = older_q;
    op_d        = op_q;
    vj_d        = vj_q;
    vk_d        = vk_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    dest_d      = dest_q;
    qj_d        = qj_q;
    qk_d        = qk_q;
    fu_enable_d = fu_enable_q;
    fu_op_d     = fu_op_q;
    fu_vj_d     = fu_vj_q;
    fu_vk_d     = fu_vk_q;
    fu_imm_d    = fu_imm_q;
    fu_pc_d     = fu_pc_q;
    fu_dest_d   = fu_dest_q;
    count_d     = '0;

    if (flush) begin
      busy_d      = '0;
      fu_enable_d = 1'b0;
    end else if (rdy) begin
      // Descending scan so the lowest matching channel is written last and wins
      for (int i = 0; i < DEPTH; i++) begin
        for (int c = NCDB - 1; c >= 0; c--) begin
          if (busy_q[i] && !rj_q[i] && cdb_valid[c] &&
              qj_q[i] == cdb_RobId[c*ROB_LOG +: ROB_LOG]) begin
            rj_d[i] = 1'b1;
            vj_d[i] = cdb_value[c*32 +: 32];
          end
          if (busy_q[i] && !rk_q[i] && cdb_valid[c] &&
              qk_q[i] == cdb_RobId[c*ROB_LOG +: ROB_LOG]) begin
            rk_d[i] = 1'b1;
            vk_d[i] = cdb_value[c*32 +: 32];
          end
        end
      end

      if (slot_free) begin
        fu_enable_d = sel_found;
        if (sel_found) begin
          fu_op_d         = op_q[sel_idx];
          fu_vj_d         = vj_q[sel_idx];
          fu_vk_d         = vk_q[sel_idx];
          fu_imm_d        = imm_q[sel_idx];
          fu_pc_d         = pc_q[sel_idx];
          fu_dest_d       = dest_q[sel_idx];
          busy_d[sel_idx] = 1'b0;
        end
      end

      if (issue_valid && free_found) begin
        busy_d[free_idx] = 1'b1;
        op_d[free_idx]   = issue_op;
        imm_d[free_idx]  = issue_Imm;
        pc_d[free_idx]   = issue_CurPC;
        dest_d[free_idx] = issue_DestRob;
        vj_d[free_idx]   = issue_Vj;
        vk_d[free_idx]   = issue_Vk;
        rj_d[free_idx]   = issue_Rj;
        rk_d[free_idx]   = issue_Rk;
        qj_d[free_idx]   = issue_Qj;
        qk_d[free_idx]   = issue_Qk;
`ifdef RS_BYPASS_EN
        for (int c = NCDB - 1; c >= 0; c--) begin
          if (!issue_Rj && cdb_valid[c] && issue_Qj == cdb_RobId[c*ROB_LOG +: ROB_LOG]) begin
            rj_d[free_idx] = 1'b1;
            vj_d[free_idx] = cdb_value[c*32 +: 32];
          end
          if (!issue_Rk && cdb_valid[c] && issue_Qk == cdb_RobId[c*ROB_LOG +: ROB_LOG]) begin
            rk_d[free_idx] = 1'b1;
            vk_d[free_idx] = cdb_value[c*32 +: 32];
          end
        end
`else
        // Operands are stored exactly as issued; forwarding is the issue stage's job
`endif
        // Every entry busy now is older than the newcomer; the newcomer is older than nobody
        for (int j = 0; j < DEPTH; j++) begin
          older_d[j][free_idx] = busy_q[j];
        end
        older_d[free_idx] = '0;
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CNT_W'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q      <= '0;
      rj_q        <= '0;
      rk_q        <= '0;
      older_q     <= '{default: '0};
      fu_enable_q <= 1'b0;
      fu_op_q     <= '0;
      fu_vj_q     <= '0;
      fu_vk_q     <= '0;
      fu_imm_q    <= '0;
      fu_pc_q     <= '0;
      fu_dest_q   <= '0;
      count_q     <= '0;
    end else begin
      busy_q      <= busy_d;
      rj_q        <= rj_d;
      rk_q        <= rk_d;
      older_q     <= older_d;
      fu_enable_q <= fu_enable_d;
      fu_op_q     <= fu_op_d;
      fu_vj_q     <= fu_vj_d;
      fu_vk_q     <= fu_vk_d;
      fu_imm_q    <= fu_imm_d;
      fu_pc_q     <= fu_pc_d;
      fu_dest_q   <= fu_dest_d;
      count_q     <= count_d;
    end
  end

  // Entry payload is only read while its busy bit is set, so it needs no reset
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    vj_q   <= vj_d;
    vk_q   <= vk_d;
    imm_q  <= imm_d;
    pc_q   <= pc_d;
    dest_q <= dest_d;
    qj_q   <= qj_d;
    qk_q   <= qk_d;
  end

  assign FU_enable  = fu_enable_q;
  assign FU_op      = fu_op_q;
  assign FU_Vj      = fu_vj_q;
  assign FU_Vk      = fu_vk_q;
  assign FU_Imm     = fu_imm_q;
  assign FU_CurPC   = fu_pc_q;
  assign FU_DestRob = fu_dest_q;
  assign RS_count   = count_q;

endmodule

// File: tb/tb_rs_gen.sv
// Bench for rs_gen (DEPTH=4, NCDB=2): directed vectors, an issue-sequence-ordered
// behavioural model compared every cycle, and hand-computed literal expectations.
module tb_rs_gen;
  localparam int DEPTH   = 4;
  localparam int NCDB    = 2;
  localparam int ROB_LOG = 4;
  localparam int OP_LOG  = 6;

  logic                       clk = 1'b0;
  logic                       rst, rdy, flush;
  logic                       issue_valid;
  logic [OP_LOG-1:0]          issue_op;
  logic [31:0]                issue_Imm, issue_CurPC, issue_Vj, issue_Vk;
  logic [ROB_LOG-1:0]         issue_DestRob, issue_Qj, issue_Qk;
  logic                       issue_Rj, issue_Rk;
  logic [NCDB-1:0]            cdb_valid;
  logic [NCDB*ROB_LOG-1:0]    cdb_RobId;
  logic [NCDB*32-1:0]         cdb_value;
  logic                       FU_enable, FU_ready;
  logic [OP_LOG-1:0]          FU_op;
  logic [31:0]                FU_Vj, FU_Vk, FU_Imm, FU_CurPC;
  logic [ROB_LOG-1:0]         FU_DestRob;
  logic                       RS_next_full;
  logic [$clog2(DEPTH+1)-1:0] RS_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rs_gen #(.DEPTH(DEPTH), .NCDB(NCDB), .ROB_LOG(ROB_LOG), .OP_LOG(OP_LOG)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_Imm(issue_Imm),
    .issue_CurPC(issue_CurPC), .issue_DestRob(issue_DestRob),
    .issue_Vj(issue_Vj), .issue_Vk(issue_Vk), .issue_Rj(issue_Rj), .issue_Rk(issue_Rk),
    .issue_Qj(issue_Qj), .issue_Qk(issue_Qk),
    .cdb_valid(cdb_valid), .cdb_RobId(cdb_RobId), .cdb_value(cdb_value),
    .FU_enable(FU_enable), .FU_ready(FU_ready), .FU_op(FU_op),
    .FU_Vj(FU_Vj), .FU_Vk(FU_Vk), .FU_Imm(FU_Imm), .FU_CurPC(FU_CurPC),
    .FU_DestRob(FU_DestRob), .RS_next_full(RS_next_full), .RS_count(RS_count)
  );

  // Model: each entry carries its issue sequence number; oldest = smallest sequence.
  typedef struct packed {
    logic               busy;
    logic               rj;
    logic               rk;
    logic [31:0]        seq;
    logic [OP_LOG-1:0]  op;
    logic [31:0]        vj, vk, imm, pc;
    logic [ROB_LOG-1:0] dest, qj, qk;
  } ent_t;

  typedef struct packed {
    ent_t [DEPTH-1:0]   e;
    logic               en;
    logic [OP_LOG-1:0]  op;
    logic [31:0]        vj, vk, imm, pc;
    logic [ROB_LOG-1:0] dest;
    logic [31:0]        nseq;
  } st_t;

  st_t ms;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit cdb_match(input logic [ROB_LOG-1:0] tag);
    for (int c = 0; c < NCDB; c++)
      if (cdb_valid[c] && cdb_RobId[c*ROB_LOG +: ROB_LOG] == tag) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] cdb_val(input logic [ROB_LOG-1:0] tag);
    for (int c = 0; c < NCDB; c++)
      if (cdb_valid[c] && cdb_RobId[c*ROB_LOG +: ROB_LOG] == tag) return cdb_value[c*32 +: 32];
    return 32'h0;
  endfunction

  function automatic int oldest_ready(input st_t s);
    int sel;
    sel = -1;
    for (int i = 0; i < DEPTH; i++)
      if (s.e[i].busy && s.e[i].rj && s.e[i].rk && (sel < 0 || s.e[i].seq < s.e[sel].seq))
        sel = i;
    return sel;
  endfunction

  function automatic st_t step(input st_t s);
    st_t n;
    int  sel;
    int  fr;
    n   = s;
    sel = oldest_ready(s);
    fr  = -1;
    for (int i = 0; i < DEPTH; i++) if (!s.e[i].busy && fr < 0) fr = i;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) n.e[i].busy = 1'b0;
      n.en = 1'b0;
      return n;
    end
    if (!rdy) return n;
    for (int i = 0; i < DEPTH; i++) begin
      if (s.e[i].busy && !s.e[i].rj && cdb_match(s.e[i].qj)) begin
        n.e[i].rj = 1'b1; n.e[i].vj = cdb_val(s.e[i].qj);
      end
      if (s.e[i].busy && !s.e[i].rk && cdb_match(s.e[i].qk)) begin
        n.e[i].rk = 1'b1; n.e[i].vk = cdb_val(s.e[i].qk);
      end
    end
    if (!s.en || FU_ready) begin
      n.en = (sel >= 0);
      if (sel >= 0) begin
        n.op = s.e[sel].op;   n.vj = s.e[sel].vj;   n.vk = s.e[sel].vk;
        n.imm = s.e[sel].imm; n.pc = s.e[sel].pc;   n.dest = s.e[sel].dest;
        n.e[sel].busy = 1'b0;
      end
    end
    if (issue_valid && fr >= 0) begin
      n.e[fr].busy = 1'b1;       n.e[fr].seq = s.nseq;      n.nseq = s.nseq + 1;
      n.e[fr].op = issue_op;     n.e[fr].imm = issue_Imm;   n.e[fr].pc = issue_CurPC;
      n.e[fr].dest = issue_DestRob;
      n.e[fr].vj = issue_Vj;     n.e[fr].vk = issue_Vk;
      n.e[fr].rj = issue_Rj;     n.e[fr].rk = issue_Rk;
      n.e[fr].qj = issue_Qj;     n.e[fr].qk = issue_Qk;
`ifdef RS_BYPASS_EN
      if (!issue_Rj && cdb_match(issue_Qj)) begin n.e[fr].rj = 1'b1; n.e[fr].vj = cdb_val(issue_Qj); end
      if (!issue_Rk && cdb_match(issue_Qk)) begin n.e[fr].rk = 1'b1; n.e[fr].vk = cdb_val(issue_Qk); end
`endif
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) ms <= '0;
    else      ms <= step(ms);
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin : cmp
    int cnt;
    bit disp;
    if (rst === 1'b1) begin
      cnt = 0;
      for (int i = 0; i < DEPTH; i++) cnt += int'(ms.e[i].busy);
      disp = rdy && !flush && (!ms.en || FU_ready) && (oldest_ready(ms) >= 0);
      chk("m_enable", FU_enable, ms.en);
      chk("m_count", RS_count, cnt);
      chk("m_next_full", RS_next_full, (cnt + int'(issue_valid) - int'(disp)) >= DEPTH);
      chk("m_op", FU_op, ms.op);
      chk("m_vj", FU_Vj, ms.vj);
      chk("m_vk", FU_Vk, ms.vk);
      chk("m_imm", FU_Imm, ms.imm);
      chk("m_pc", FU_CurPC, ms.pc);
      chk("m_dest", FU_DestRob, ms.dest);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    issue_valid = 1'b0;
    cdb_valid   = '0;
    cdb_RobId   = '0;
    cdb_value   = '0;
  endtask

  task automatic issue_ent(input logic [OP_LOG-1:0] op, input logic [31:0] vj, input logic [31:0] vk,
                           input logic rj, input logic rk, input logic [ROB_LOG-1:0] qj,
                           input logic [ROB_LOG-1:0] qk, input logic [ROB_LOG-1:0] dest);
    issue_valid   = 1'b1;
    issue_op      = op;
    issue_Vj      = vj;
    issue_Vk      = vk;
    issue_Rj      = rj;
    issue_Rk      = rk;
    issue_Qj      = qj;
    issue_Qk      = qk;
    issue_DestRob = dest;
    issue_Imm     = vj ^ 32'h0000_F0F0;
    issue_CurPC   = 32'h1000 + {26'h0, dest, 2'b00};
  endtask

  task automatic set_cdb(input int c, input logic [ROB_LOG-1:0] tag, input logic [31:0] val);
    cdb_valid[c]                   = 1'b1;
    cdb_RobId[c*ROB_LOG +: ROB_LOG] = tag;
    cdb_value[c*32 +: 32]          = val;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; FU_ready = 1'b1;
    issue_ent('0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    clear_in();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_enable", FU_enable, 0);
    chk("reset_count", RS_count, 0);
    chk("reset_next_full", RS_next_full, 0);
    chk("reset_vj", FU_Vj, 0);
    rst = 1'b1;

    // Fill with four not-ready entries, then a fifth issue is dropped
    for (int k = 0; k < 4; k++) begin
      issue_ent(6'(k + 1), 32'h100 + k, 32'h200 + k, 1'b0, 1'b1, 4'(k + 1), 4'h0, 4'(8 + k));
      cyc();
    end
    issue_ent(6'h3f, 32'hDEAD, 32'hBEEF, 1'b0, 1'b1, 4'hF, 4'h0, 4'hF);
    chk("full_count", RS_count, 4);
    chk("full_next_full", RS_next_full, 1);
    cyc();
    clear_in();
    chk("drop_count", RS_count, 4);
    set_cdb(0, 4'h1, 32'hAAAA);
    cyc();
    clear_in();
    cyc();
    chk("full_disp_en", FU_enable, 1);
    chk("full_disp_vj", FU_Vj, 32'hAAAA);
    chk("full_disp_dest", FU_DestRob, 8);
    chk("full_disp_count", RS_count, 3);
    FU_ready = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0; FU_ready = 1'b1;
    chk("flush_count", RS_count, 0);
    chk("flush_enable", FU_enable, 0);

    // Age order: A, B, C issued; C woken first, then A and B together
    issue_ent(6'd10, 32'h0, 32'hB0, 1'b0, 1'b1, 4'd5, 4'd0, 4'd1); cyc();
    issue_ent(6'd11, 32'h0, 32'hB1, 1'b0, 1'b1, 4'd6, 4'd0, 4'd2); cyc();
    issue_ent(6'd12, 32'h0, 32'hB2, 1'b0, 1'b1, 4'd7, 4'd0, 4'd3); cyc();
    clear_in();
    set_cdb(0, 4'd7, 32'h77);
    cyc();
    clear_in();
    set_cdb(0, 4'd5, 32'h55);
    set_cdb(1, 4'd6, 32'h66);
    cyc();
    clear_in();
    chk("age_first_dest", FU_DestRob, 3);
    chk("age_first_vj", FU_Vj, 32'h77);
    cyc();
    chk("age_second_dest", FU_DestRob, 1);
    chk("age_second_vj", FU_Vj, 32'h55);
    cyc();
    chk("age_third_dest", FU_DestRob, 2);
    chk("age_third_vj", FU_Vj, 32'h66);
    cyc();
    chk("age_drained_en", FU_enable, 0);

    // Two channels wake both operands on one edge; same tag on both channels -> channel 0 wins
    issue_ent(6'd20, 32'h0, 32'h0, 1'b0, 1'b0, 4'd3, 4'd5, 4'd6); cyc();
    issue_ent(6'd21, 32'h0, 32'h7, 1'b0, 1'b1, 4'd9, 4'd0, 4'd7); cyc();
    clear_in();
    set_cdb(0, 4'd3, 32'h11);
    set_cdb(1, 4'd5, 32'h22);
    cyc();
    clear_in();
    cyc();
    chk("dual_en", FU_enable, 1);
    chk("dual_vj", FU_Vj, 32'h11);
    chk("dual_vk", FU_Vk, 32'h22);
    chk("dual_dest", FU_DestRob, 6);
    set_cdb(0, 4'd9, 32'h99);
    set_cdb(1, 4'd9, 32'hBB);
    cyc();
    clear_in();
    cyc();
    chk("prio_vj", FU_Vj, 32'h99);
    chk("prio_dest", FU_DestRob, 7);
    cyc();

    // Back-pressure: payload stays put while FU_ready is low
    FU_ready = 1'b0;
    issue_ent(6'd30, 32'h301, 32'h302, 1'b1, 1'b1, 4'd0, 4'd0, 4'd4); cyc();
    issue_ent(6'd31, 32'h311, 32'h312, 1'b1, 1'b1, 4'd0, 4'd0, 4'd5); cyc();
    clear_in();
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("hold_en", FU_enable, 1);
      chk("hold_dest", FU_DestRob, 4);
      chk("hold_vj", FU_Vj, 32'h301);
    end
    FU_ready = 1'b1;
    cyc();
    chk("release_dest", FU_DestRob, 5);
    chk("release_vj", FU_Vj, 32'h311);
    cyc();
    chk("release_idle_en", FU_enable, 0);

    // rdy=0 freezes everything; flush still acts with rdy=0
    FU_ready = 1'b0;
    issue_ent(6'd40, 32'h900, 32'h901, 1'b1, 1'b1, 4'd0, 4'd0, 4'd9); cyc();
    clear_in();
    cyc();
    rdy = 1'b0; FU_ready = 1'b1;
    issue_ent(6'd41, 32'h910, 32'h911, 1'b1, 1'b1, 4'd0, 4'd0, 4'd10);
    set_cdb(0, 4'd1, 32'h5);
    cyc();
    cyc();
    chk("freeze_en", FU_enable, 1);
    chk("freeze_dest", FU_DestRob, 9);
    chk("freeze_count", RS_count, 0);
    clear_in();
    flush = 1'b1;
    cyc();
    flush = 1'b0; rdy = 1'b1;
    chk("flush_nordy_en", FU_enable, 0);

    // Asynchronous reset in the middle of a dispatch
    FU_ready = 1'b0;
    issue_ent(6'd50, 32'hC00, 32'hC01, 1'b1, 1'b1, 4'd0, 4'd0, 4'd12); cyc();
    issue_ent(6'd51, 32'h0, 32'h0, 1'b0, 1'b1, 4'd2, 4'd0, 4'd14); cyc();
    clear_in();
    chk("pre_rst_en", FU_enable, 1);
    chk("pre_rst_count", RS_count, 1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_en", FU_enable, 0);
    chk("async_rst_count", RS_count, 0);
    chk("async_rst_dest", FU_DestRob, 0);
    chk("async_rst_vj", FU_Vj, 0);
    chk("async_rst_op", FU_op, 0);
    #2 rst = 1'b1;
    FU_ready = 1'b1;
    issue_ent(6'd52, 32'hD00, 32'hD01, 1'b1, 1'b1, 4'd0, 4'd0, 4'd13);
    cyc();
    clear_in();
    chk("post_rst_count", RS_count, 1);
    cyc();
    chk("post_rst_en", FU_enable, 1);
    chk("post_rst_dest", FU_DestRob, 13);
    cyc();

    // Issue while dispatching under back-pressure, refill the freed slot, then drain in age order
    FU_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      issue_ent(6'(60 + k), 32'h500 + k, 32'h600 + k, 1'b1, 1'b1, 4'd0, 4'd0, 4'(k));
      cyc();
    end
    clear_in();
    chk("refill_count", RS_count, 4);
    FU_ready = 1'b1;
    cyc();
    chk("drain_first_dest", FU_DestRob, 1);
    cyc();
    chk("drain_second_dest", FU_DestRob, 2);
    repeat (5) cyc();
    chk("drain_done_count", RS_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rs_gen.md
RS_GEN -- requirements
Module: rs_gen

Interface
REQ-001 SHALL expose parameter DEPTH, default 8, number of entries (power of two, 2..32).
REQ-002 SHALL expose parameter NCDB, default 2, number of result broadcast channels.
REQ-003 SHALL expose parameter ROB_LOG, default 4, ROB tag width.
REQ-004 SHALL expose parameter OP_LOG, default 6, opcode width.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset (asserted at 0).
REQ-007 SHALL have port rdy  input  1  global enable; 0 freezes all state.
REQ-008 SHALL have port flush  input  1  misprediction clear.
REQ-009 SHALL have ports issue_valid  input 1, issue_op  input OP_LOG, issue_Imm and issue_CurPC  input 32 each, issue_DestRob  input ROB_LOG: new entry.
REQ-010 SHALL have ports issue_Vj and issue_Vk  input 32, issue_Rj and issue_Rk  input 1, issue_Qj and issue_Qk  input ROB_LOG: operands, ready flags, producer tags.
REQ-011 SHALL have ports cdb_valid  input NCDB, cdb_RobId  input NCDB*ROB_LOG, cdb_value  input NCDB*32: packed broadcast channels, channel c in slice c.
REQ-012 SHALL have ports FU_enable  output 1 and FU_ready  input 1: dispatch valid/ready handshake.
REQ-013 SHALL have ports FU_op  output OP_LOG, FU_Vj, FU_Vk, FU_Imm and FU_CurPC  output 32 each, FU_DestRob  output ROB_LOG: registered dispatch payload.
REQ-014 SHALL have ports RS_next_full  output 1 and RS_count  output clog2(DEPTH+1): occupancy status.

Function
REQ-015 SHALL write an accepted issue into the lowest-index free entry; issue while all DEPTH entries are busy SHALL be dropped, with no state change.
REQ-016 SHALL record, per entry, an age relation (age matrix or equivalent) so that every busy entry is totally ordered by issue order.
REQ-017 SHALL, at each enabled edge, set Rx and capture Vx for every busy entry operand with Rx=0 whose Qx equals cdb_RobId[c] with cdb_valid[c]=1; when several channels match, the lowest c wins.
REQ-018 SHALL treat the dispatch slot as free when FU_enable=0 or FU_ready=1; when free and at least one busy entry has Rj=Rk=1, SHALL load the payload of the oldest such entry, set FU_enable=1 and free that entry on the same edge.
REQ-019 SHALL clear FU_enable when the slot is free and no entry is ready; FU_enable=1 with FU_ready=0 SHALL hold the payload stable.
REQ-020 SHALL meet these latencies: an operand ready after edge e dispatches at edge e+1 at the earliest, and issue at edge e produces FU_enable at edge e+1 at the earliest.
REQ-021 SHALL process issue, wakeup and dispatch on the same edge without loss; a freed entry SHALL be reusable at the next edge.
REQ-022 SHALL drive RS_next_full combinationally as 1 when RS_count + issue_valid - dispatch_this_edge >= DEPTH, and RS_count as the registered number of busy entries.
REQ-023 SHALL, on an edge with flush=1 (regardless of rdy), clear all busy bits and FU_enable, overriding issue and dispatch.
REQ-024 SHALL, with rdy=0 and flush=0, hold every register, including FU_enable and the payload.

Reset
REQ-025 SHALL, while rst=0, asynchronously clear every busy bit, age state, FU_enable, RS_count and all FU_* payload outputs to 0; RS_next_full SHALL read 0 with issue_valid=0.
REQ-026 SHALL treat a reset mid-operation as discarding all entries and any pending dispatch; the first enabled edge after release accepts issue.

Configuration
REQ-027 SHALL, with RS_BYPASS_EN defined, mark an issuing operand ready and take cdb_value when its Qx matches a valid channel on the issue edge; without it, the operand is stored exactly as issued and the issue stage is responsible for the forward.

Verification
REQ-028 SHALL verify, with DEPTH=4 and NCDB=2, that issuing 4 not-ready entries gives RS_count=4 and RS_next_full=1, and that a fifth issue is dropped.
REQ-029 SHALL verify that entries issued in order A(idx0), B(idx1), C(idx2), with C woken first and then A and B woken on the same edge, dispatch in the order C, A, B.
REQ-030 SHALL verify that same-edge cdb0 {tag 3, 0x11} and cdb1 {tag 5, 0x22} wake an entry with Qj=3, Qk=5, giving Vj=0x11, Vk=0x22 and FU_enable at the next edge.
REQ-031 SHALL verify that holding FU_ready=0 for 3 cycles with 2 ready entries keeps the payload stable, and that after FU_ready=1 the second entry dispatches at the next edge.
REQ-032 SHALL verify that flush with 3 busy entries and FU_enable=1 gives RS_count=0 and FU_enable=0 after the edge, and that a pulse of rst=0 mid-dispatch clears the outputs without waiting for clk.
